muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_sequencer_div_step.sv | 27 ++
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension multiply/divide sequencer.
// The divider datapath is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int XLEN = 64;
    localparam int ITER = 64;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Two's-complement negate when n is set; used for sign correction of magnitudes.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference when it does not go negative.
// Only present when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor, so the shifted value is < 2*divisor and the kept result always fits XLEN bits
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[XLEN];
        rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule
`endif

// File: rtl/muldiv_sequencer.sv
// Iterative RV64 M-extension unit: 64-step shift-add multiplier and, when
// MULDIV_DIV_EN is defined, a 64-step restoring divider with one-cycle fast
// paths for divide-by-zero and signed overflow. Without MULDIV_DIV_EN a
// divide op completes one cycle after acceptance with o_illegal set.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic            o_illegal
);

    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t              state, state_next;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   acc;       // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     aux;       // multiplicand or divisor magnitude
    logic [1:0]          op;
    logic [4:0]          rd_q;
    logic                q_neg;     // product sign, or quotient sign for divides
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_out;
    logic [XLEN-1:0]     res_final;

    logic                accept, busy, iter_done;
    logic                rs1_signed, rs2_signed, a_neg, b_neg;
    logic [XLEN-1:0]     mag_a, mag_b;

    // Multiply step and sign-corrected product
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod;
    logic [XLEN-1:0]     mul_res;

    assign accept = (state == IDLE) && i_valid && !i_flush;
    assign busy   = (state == MUL) || (state == DIV);

    assign rs1_signed = !(i_funct3 inside {OP_MULHU, OP_DIVU, OP_REMU});
    assign rs2_signed = i_funct3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign a_neg      = rs1_signed & i_rs1_value[XLEN-1];
    assign b_neg      = rs2_signed & i_rs2_value[XLEN-1];
    assign mag_a      = cond_neg(i_rs1_value, a_neg);
    assign mag_b      = cond_neg(i_rs2_value, b_neg);

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, aux} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign prod     = q_neg ? (~mul_next + 1'b1) : mul_next;
    assign mul_res  = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic                fast;      // op resolved at acceptance, no iterations needed
    logic                r_neg;     // remainder takes the dividend's sign
    logic [XLEN-1:0]     rem_next;
    logic                q_bit;
    logic [XLEN-1:0]     div_res;
    logic                div_zero, div_ovf, fast_in;
    logic [XLEN-1:0]     fast_res;

    div_step u_div_step (
        .rem      (acc[2*XLEN-1:XLEN]),
        .bit_in   (acc[XLEN-1]),
        .divisor  (aux),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign div_zero  = (i_rs2_value == '0);
    assign div_ovf   = !i_funct3[0] && (i_rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_value == '1);
    assign fast_in   = div_zero || div_ovf;
    assign fast_res  = div_zero ? (i_funct3[1] ? i_rs1_value : '1)
                                : (i_funct3[1] ? '0 : i_rs1_value);
    assign div_res   = op[1] ? cond_neg(rem_next, r_neg)
                             : cond_neg({acc[XLEN-2:0], q_bit}, q_neg);
    assign acc_next  = (state == DIV) ? {rem_next, acc[XLEN-2:0], q_bit} : mul_next;
    assign res_final = (state == MUL) ? mul_res : (fast ? acc[XLEN-1:0] : div_res);
    assign iter_done = (count == LAST) || ((state == DIV) && fast);
    assign o_illegal = 1'b0;
`else
    logic                illegal;

    assign acc_next  = mul_next;
    assign res_final = (state == MUL) ? mul_res : '0;
    assign iter_done = (count == LAST) || (state == DIV);
    assign o_illegal = (state == DONE) && illegal;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: flush aborts any busy state, DONE always lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = i_funct3[2] ? DIV : MUL;
            MUL, DIV: begin
                if (i_flush)        state_next = IDLE;
                else if (iter_done) state_next = DONE;
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate while busy, capture result on entry to DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count    <= '0;
            acc      <= '0;
            aux      <= '0;
            op       <= '0;
            rd_q     <= '0;
            q_neg    <= 1'b0;
            result_q <= '0;
            rd_out   <= '0;
`ifdef MULDIV_DIV_EN
            fast     <= 1'b0;
            r_neg    <= 1'b0;
`else
            illegal  <= 1'b0;
`endif
        end else if (accept) begin
            op    <= i_funct3[1:0];
            rd_q  <= i_rd;
            count <= '0;
            q_neg <= a_neg ^ b_neg;
            if (!i_funct3[2]) begin
                acc <= {{XLEN{1'b0}}, mag_b};
                aux <= mag_a;
            end else begin
`ifdef MULDIV_DIV_EN
                acc   <= {{XLEN{1'b0}}, fast_in ? fast_res : mag_a};
                aux   <= mag_b;
                fast  <= fast_in;
                r_neg <= a_neg;
`else
                acc   <= '0;
`endif
            end
`ifndef MULDIV_DIV_EN
            illegal <= i_funct3[2];
`endif
        end else if (busy && !i_flush) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (iter_done) begin
                result_q <= res_final;
                rd_out   <= rd_q;
            end
        end
    end

    assign o_ready     = (state == IDLE);
    assign o_stall     = busy || ((state == IDLE) && i_valid);
    assign o_valid     = (state == DONE);
    assign o_reg_write = o_valid;
    assign o_result    = result_q;
    assign o_rd        = rd_out;

endmodule
